// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - command queue and sequencer feeding spi_master_4byte
//
// Purpose: buffers {mode, target, word} entries in a FIFO and, on start,
// drains them one SPI transaction at a time. Each transaction is loaded,
// given a one-cycle setup, triggered, and awaited. The received word is
// returned, and an idle gap is inserted before the next transaction.
//
// Optional feature macro: SPI_SEQ_TIMEOUT_EN
//   defined   - WAIT is bounded by TIMEOUT cycles. On expiry, err is set, the
//               FIFO is flushed and the run ends with done.
//   undefined - WAIT waits indefinitely and err is tied low.
//
// Ports:
//   CLK_IN, RST            clock (rising edge), synchronous active-high reset
//   wr_en/wr_data/wr_target/wr_mode   queue push interface
//   full, level            queue status
//   start, busy, done      run control and status
//   rd_data, rd_valid      last received word and its update pulse
//   err                    sticky timeout flag
//   din, target, trigger, CPOL, CPHA  drive the SPI master
//   dout, valid            completion data and pulse from the SPI master

module spi_cmd_sequencer #(
  parameter int N       = 10,
  parameter int C       = 16,
  parameter int DEPTH   = 8,
  parameter int GAP     = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic                       CLK_IN,
  input  logic                       RST,
  input  logic                       wr_en,
  input  logic [C-1:0]               wr_data,
  input  logic [N-1:0]               wr_target,
  input  logic [1:0]                 wr_mode,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [C-1:0]               rd_data,
  output logic                       rd_valid,
  output logic                       err,
  output logic [C-1:0]               din,
  output logic [N-1:0]               target,
  output logic                       trigger,
  output logic                       CPOL,
  output logic                       CPHA,
  input  logic [C-1:0]               dout,
  input  logic                       valid
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = C + N + 2;
  // One counter serves both the gap and the WAIT timeout, sized for either.
  localparam int CW = $clog2(GAP + TIMEOUT + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_FIRE,
    S_WAIT,
    S_GAP
  } state_t;

  state_t state_q, state_d;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic [CW-1:0] cnt;
  logic [EW-1:0] head;
  logic          push, pop, flush, run_done, timeout_hit;

  assign full    = (count == LW'(DEPTH));
  assign level   = count;
  assign push    = wr_en && !full;
  assign head    = mem[rd_ptr];
  assign busy    = (state_q != S_IDLE);
  // Gating with RST makes trigger fall in the very cycle reset is sampled.
  assign trigger = (state_q == S_FIRE) && !RST;

`ifdef SPI_SEQ_TIMEOUT_EN
  logic err_q;
  assign err         = err_q;
  assign timeout_hit = (state_q == S_WAIT) && !valid && (cnt == CW'(TIMEOUT - 1));
`else
  assign err         = 1'b0;
  assign timeout_hit = 1'b0;
`endif

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    flush    = 1'b0;
    run_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count != LW'(0)) state_d = S_LOAD;
          else                 run_done = 1'b1;
        end
      end
      S_LOAD: begin
        pop     = 1'b1;
        state_d = S_SETUP;
      end
      S_SETUP: state_d = S_FIRE;
      S_FIRE:  state_d = S_WAIT;
      S_WAIT: begin
        // A completion in the last timeout cycle still counts as a success.
        if (valid) begin
          state_d = S_GAP;
        end else if (timeout_hit) begin
          state_d  = S_IDLE;
          flush    = 1'b1;
          run_done = 1'b1;
        end
      end
      S_GAP: begin
        // The first GAP cycle overlaps the rd_valid pulse; GAP more follow.
        if (cnt == CW'(GAP)) begin
          if (count != LW'(0)) begin
            state_d = S_LOAD;
          end else begin
            state_d  = S_IDLE;
            run_done = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge CLK_IN) begin
    if (push) mem[wr_ptr] <= {wr_mode, wr_target, wr_data};
  end

  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      state_q  <= S_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      din      <= '0;
      target   <= '0;
      CPOL     <= 1'b0;
      CPHA     <= 1'b0;
    end else begin
      state_q  <= state_d;
      done     <= run_done;
      rd_valid <= 1'b0;

      if (flush) begin
        // A push coinciding with a timeout flush is discarded with the rest.
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + LW'(1);
          2'b01:   count <= count - LW'(1);
          default: count <= count;
        endcase
      end

      if (pop) {CPOL, CPHA, target, din} <= head;

      // Slave select drops as soon as the transaction leaves WAIT.
      if (state_q == S_WAIT && (valid || timeout_hit)) target <= '0;

      if (state_q == S_WAIT && valid) begin
        rd_data  <= dout;
        rd_valid <= 1'b1;
      end

      if (state_d != state_q)
        cnt <= '0;
      else if (state_q == S_WAIT || state_q == S_GAP)
        cnt <= cnt + CW'(1);
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      err_q <= 1'b0;
    end else if (state_q == S_IDLE && start && count != LW'(0)) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// tb/tb_spi_cmd_sequencer.sv - directed self-checking bench for spi_cmd_sequencer

module tb_spi_cmd_sequencer;

  localparam int N = 10;
  localparam int C = 16;
  localparam int DEPTH = 8;
  localparam int GAP = 4;
  localparam int TOUT = 20;
  localparam int RESP_LAT = 3;

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic          wr_en = 1'b0;
  logic [C-1:0]  wr_data = '0;
  logic [N-1:0]  wr_target = '0;
  logic [1:0]    wr_mode = '0;
  logic          full;
  logic [3:0]    level;
  logic          start = 1'b0;
  logic          busy, done, rd_valid, err, trigger, CPOL, CPHA;
  logic [C-1:0]  rd_data, din;
  logic [N-1:0]  target;
  logic [C-1:0]  dout = '0;
  logic          valid = 1'b0;

  spi_cmd_sequencer #(.N(N), .C(C), .DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TOUT)) dut (
    .CLK_IN(clk), .RST(RST),
    .wr_en(wr_en), .wr_data(wr_data), .wr_target(wr_target), .wr_mode(wr_mode),
    .full(full), .level(level),
    .start(start), .busy(busy), .done(done),
    .rd_data(rd_data), .rd_valid(rd_valid), .err(err),
    .din(din), .target(target), .trigger(trigger), .CPOL(CPOL), .CPHA(CPHA),
    .dout(dout), .valid(valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  logic [C-1:0] tdin  [16];
  logic [N-1:0] ttgt  [16];
  logic [1:0]   tmode [16];
  int           tcyc  [16];
  int           vcyc  [16];
  logic [C-1:0] resp  [16];
  logic [C-1:0] rdlog [16];
  int trig_n, rv_n, done_n, done_cyc, resp_cd;
  bit resp_en = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic clr_logs();
    trig_n = 0; rv_n = 0; done_n = 0; done_cyc = -1; resp_cd = 0;
  endtask

  // Advance to the next falling edge, observe outputs, and act as the SPI master.
  task automatic tick();
    @(negedge clk);
    valid = 1'b0;
    if (trigger) begin
      if (trig_n < 16) begin
        tdin[trig_n] = din; ttgt[trig_n] = target;
        tmode[trig_n] = {CPOL, CPHA}; tcyc[trig_n] = cyc;
      end
      trig_n++;
      if (resp_en) resp_cd = RESP_LAT;
    end else if (resp_cd > 0) begin
      resp_cd--;
      if (resp_cd == 0 && trig_n <= 16) begin
        valid = 1'b1;
        dout = resp[trig_n-1];
        vcyc[trig_n-1] = cyc;
      end
    end
    if (rd_valid) begin
      if (rv_n < 16) rdlog[rv_n] = rd_data;
      rv_n++;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
  endtask

  task automatic push(input logic [C-1:0] d, input logic [N-1:0] t, input logic [1:0] m);
    wr_en = 1'b1; wr_data = d; wr_target = t; wr_mode = m;
    tick();
    wr_en = 1'b0;
  endtask

  // Returns the cycle in which start was presented.
  task automatic pulse_start(output int s);
    s = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    d0 = done_n;
    for (int i = 0; i < budget && done_n == d0; i++) tick();
    if (done_n == d0) check({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic wait_trig(input string tag, input int target_n, input int budget);
    for (int i = 0; i < budget && trig_n < target_n; i++) tick();
    if (trig_n < target_n) check({tag, "_trig_timeout"}, 0, 1);
  endtask

  int s, t0;

  initial begin
    clr_logs();
    repeat (3) tick();
    RST = 1'b0;
    tick();

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_level", level, 0);
    check("rst_full", full, 0);
    check("rst_done", done, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_trigger", trigger, 0);
    check("rst_err", err, 0);
    check("rst_din", din, 0);
    check("rst_target", target, 0);
    check("rst_mode", {CPOL, CPHA}, 0);
    check("rst_rd_data", rd_data, 0);

    // Single entry
    clr_logs();
    resp[0] = 16'h1234;
    push(16'hA5C3, 10'h004, 2'b10);
    check("t1_level", level, 1);
    pulse_start(s);
    check("t1_busy_c1", busy, 1);
    tick();
    check("t1_cpol_c2", CPOL, 1);
    check("t1_target_c2", target, 10'h004);
    wait_done("t1", 100);
    check("t1_trig_n", trig_n, 1);
    check("t1_trig_cyc", tcyc[0] - s, 3);
    check("t1_din", tdin[0], 16'hA5C3);
    check("t1_tgt", ttgt[0], 10'h004);
    check("t1_mode", tmode[0], 2'b10);
    check("t1_rv_n", rv_n, 1);
    check("t1_rd_data", rdlog[0], 16'h1234);
    check("t1_done_cyc", done_cyc - s, 12);
    check("t1_done_n", done_n, 1);
    check("t1_busy_at_done", busy, 0);
    check("t1_target_idle", target, 0);
    check("t1_cpol_hold", CPOL, 1);

    // Three entries in FIFO order
    clr_logs();
    resp[0] = 16'hAAAA; resp[1] = 16'hBBBB; resp[2] = 16'hCCCC;
    push(16'h1111, 10'h001, 2'b00);
    push(16'h2222, 10'h002, 2'b11);
    push(16'h3333, 10'h200, 2'b01);
    check("t2_level3", level, 3);
    pulse_start(s);
    wait_done("t2", 200);
    check("t2_trig_n", trig_n, 3);
    check("t2_din0", tdin[0], 16'h1111);
    check("t2_din1", tdin[1], 16'h2222);
    check("t2_din2", tdin[2], 16'h3333);
    check("t2_tgt0", ttgt[0], 10'h001);
    check("t2_tgt1", ttgt[1], 10'h002);
    check("t2_tgt2", ttgt[2], 10'h200);
    check("t2_mode0", tmode[0], 2'b00);
    check("t2_mode1", tmode[1], 2'b11);
    check("t2_mode2", tmode[2], 2'b01);
    check("t2_gap01", tcyc[1] - vcyc[0], 8);
    check("t2_gap12", tcyc[2] - vcyc[1], 8);
    check("t2_rd0", rdlog[0], 16'hAAAA);
    check("t2_rd2", rdlog[2], 16'hCCCC);
    check("t2_done_after_v", done_cyc - vcyc[2], 6);
    check("t2_done_n", done_n, 1);
    check("t2_level0", level, 0);

    // Nine pushes into eight slots, plus one more pushed during WAIT
    clr_logs();
    for (int k = 0; k < 16; k++) resp[k] = 16'hF000 + 16'(k);
    for (int k = 0; k < 9; k++) begin
      push(16'h0100 + 16'(k), 10'(1 << (k % N)), 2'(k));
      if (k == 7) begin
        check("t3_full8", full, 1);
        check("t3_level8", level, 8);
      end
    end
    check("t3_level_after9", level, 8);
    check("t3_full_after9", full, 1);
    pulse_start(s);
    wait_trig("t3", 1, 50);
    tick();
    push(16'hBEEF, 10'h3FF, 2'b11);
    wait_done("t3", 400);
    check("t3_trig_n", trig_n, 9);
    check("t3_din0", tdin[0], 16'h0100);
    check("t3_din7", tdin[7], 16'h0107);
    check("t3_din8_extra", tdin[8], 16'hBEEF);
    check("t3_tgt8", ttgt[8], 10'h3FF);
    check("t3_rd8", rdlog[8], 16'hF008);
    check("t3_done_n", done_n, 1);
    check("t3_level0", level, 0);

    // Start with an empty FIFO
    clr_logs();
    pulse_start(s);
    check("t4_done_next", done, 1);
    check("t4_done_cyc", done_cyc - s, 1);
    check("t4_busy", busy, 0);
    tick();
    check("t4_done_single", done, 0);
    check("t4_no_trig", trig_n, 0);

`ifdef SPI_SEQ_TIMEOUT_EN
    // Master never responds: WAIT times out
    clr_logs();
    resp_en = 1'b0;
    push(16'h5555, 10'h010, 2'b00);
    push(16'h6666, 10'h020, 2'b00);
    pulse_start(s);
    wait_trig("t5", 1, 50);
    t0 = tcyc[0];
    wait_done("t5", 100);
    check("t5_done_cyc", done_cyc - (t0 + 1), TOUT);
    check("t5_err", err, 1);
    check("t5_level", level, 0);
    check("t5_no_rv", rv_n, 0);
    check("t5_busy", busy, 0);
    resp_en = 1'b1;
    resp[0] = 16'h0F0F;
    push(16'h7777, 10'h040, 2'b00);
    pulse_start(s);
    check("t5_err_cleared", err, 0);
    wait_done("t5b", 100);
    check("t5_rd_after", rdlog[0], 16'h0F0F);
`endif

    // Reset during WAIT
    clr_logs();
    resp_en = 1'b0;
    push(16'h9999, 10'h080, 2'b11);
    push(16'h8888, 10'h100, 2'b01);
    pulse_start(s);
    wait_trig("t6", 1, 50);
    tick();
    check("t6_in_wait_target", target, 10'h080);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_level", level, 0);
    check("t6_target", target, 0);
    check("t6_din", din, 0);
    check("t6_mode", {CPOL, CPHA}, 0);
    check("t6_rd_data", rd_data, 0);
    check("t6_trigger", trigger, 0);
    check("t6_err", err, 0);
    resp_en = 1'b1;
    repeat (20) tick();
    check("t6_no_retrigger", trig_n, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_cmd_sequencer.md
# spi_cmd_sequencer

Command queue and sequencer that sits directly upstream of `spi_master_4byte` and drives its `din`, `target`, `trigger`, `CPOL` and `CPHA` inputs.
- Control logic pushes `{mode, target, word}` entries into an internal FIFO, then pulses `start`.
- The block then drains the queue one SPI transaction at a time. For each entry it waits for the master's `valid`, returns the captured `dout`, and inserts a programmable idle gap between transactions.

## Interface
Parameters:
- `N`, 10: slave-select width; must match the master's `N`.
- `C`, 16: SPI word width; must match the master's `C`.
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `GAP`, 4: idle cycles between transactions; ≥1.
- `TIMEOUT`, 65535: maximum cycles spent in WAIT; ≥1.

Ports:
- `CLK_IN` in 1: sole clock, rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `wr_en` in 1: push one entry.
- `wr_data` in C: word to transmit.
- `wr_target` in N: one-hot slave select for the entry.
- `wr_mode` in 2: `{CPOL, CPHA}` for the entry.
- `full` out 1: FIFO holds DEPTH entries.
- `level` out $clog2(DEPTH)+1: current entry count.
- `start` in 1: begin draining the queue.
- `busy` out 1: sequencer is not IDLE.
- `done` out 1: one-cycle pulse when a run ends.
- `rd_data` out C: last received word.
- `rd_valid` out 1: one-cycle pulse; `rd_data` has been updated.
- `err` out 1: sticky timeout flag.
- `din` out C: to master.
- `target` out N: to master.
- `trigger` out 1: to master.
- `CPOL` out 1: to master.
- `CPHA` out 1: to master.
- `dout` in C: from master.
- `valid` in 1: from master; one-cycle completion pulse.

## Operation
FIFO:
- Each entry is C+N+2 bits.
- Push when `wr_en && !full`. A push while full is silently dropped and `level` is unchanged.
- Pushes are accepted in every state. Entries pushed during a run are drained within the same run.
- Push and pop in the same cycle leave `level` unchanged and both operations take effect.

FSM states are IDLE, LOAD, SETUP, FIRE, WAIT, GAP:
- **IDLE**
  - `start` with `level>0`: go to LOAD and clear `err`.
  - `start` with `level==0`: pulse `done` on the next cycle and stay in IDLE.
- **LOAD**: pop the head entry, register it into `din`, `target`, `CPOL` and `CPHA`, then go to SETUP.
- **SETUP**: hold one cycle so the master's SPI_CLK idle level settles on a mode change, then go to FIRE.
- **FIRE**: `trigger`=1 for exactly one cycle, then go to WAIT.
- **WAIT**
  - On `valid`: capture `rd_data<=dout`, pulse `rd_valid` on the next cycle, go to GAP.
  - `valid` arriving while the FSM is in any other state is ignored.
- **GAP**
  - Count GAP cycles.
  - Then go to LOAD if `level>0`.
  - Otherwise go to IDLE and pulse `done`.
- `start` is ignored while `busy`.

Output hold rules:
- `din` and `target` are held stable from LOAD through the end of WAIT.
- `target` returns to all-zeros in GAP and IDLE.
- `CPOL` and `CPHA` hold their last value, so no clock-polarity glitch occurs between transactions.

## Timing
Reset values:
- State IDLE, FIFO empty, `level`=0, `full`=0, `busy`=0.
- `done`, `rd_valid`, `trigger` and `err` are 0.
- `din`, `rd_data`, `target`, `CPOL` and `CPHA` are all zero.
- `RST` during a run abandons the transaction and flushes the FIFO; `trigger` drops in the same cycle the reset is sampled.

Latency:
- `start` sampled at cycle 0: LOAD at 1, SETUP at 2, `trigger` high at cycle 3.
- `valid` at cycle v: `rd_valid` and `rd_data` at v+1.
- Next `trigger` at v+1+GAP+3.
- `done` is asserted the cycle after the last GAP cycle.
- `busy` is high from cycle 1 until the cycle `done` is asserted; `busy` is low in that cycle.

## Configuration
Macro `SPI_SEQ_TIMEOUT_EN`:
- **Defined**
  - A cycle counter runs in WAIT.
  - When it reaches TIMEOUT with no `valid`: set `err`, flush the FIFO, go to IDLE and pulse `done`.
  - No `rd_valid` is generated for the aborted transaction.
- **Undefined**
  - WAIT waits indefinitely.
  - `err` is tied to 0 and TIMEOUT is unused.

## Test plan
- Push 1 entry (`0xA5C3`, `target=0x004`, mode 2'b10), `start` → `CPOL=1` by cycle 2, single `trigger` at cycle 3, `target=0x004`. Master `valid` with `dout=0x1234` → `rd_data=0x1234`, `rd_valid` 1 cycle, then GAP (4), then `done`.
- Push 3 entries with differing targets and modes → three triggers in FIFO order, each spaced ≥ GAP+3 cycles after the previous `valid`; `level` goes 3→0; one `done` for the run.
- Push 9 entries with DEPTH=8 → `full`=1 after the 8th, 9th dropped, exactly 8 transactions. Also: a push during WAIT is drained within the same run.
- `start` with an empty FIFO → `done` the next cycle, `busy` stays 0, no `trigger`.
- With `SPI_SEQ_TIMEOUT_EN` and TIMEOUT=20, never assert `valid` → `err`=1 and `done` 20 cycles after WAIT entry, FIFO flushed; a new `start` clears `err`. Also: `RST` asserted mid-WAIT → all outputs at reset values the next cycle.
